// File: rtl/multicycle_ctrl_if.sv
// Memory request/completion handshake between the multicycle controller
// and the shared instruction/data memory port.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_wr;
    logic mem_isel;
    logic mem_done;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_isel,
        input  mem_done
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_isel,
        output mem_done
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit unpipelined core.
// Define MULTICYCLE_CTRL_TIMEOUT_EN to add the memory wait timeout fault.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    input  logic              alu_zero,
    multicycle_ctrl_if.master mem,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              alu_latch,
    output logic              rf_we,
    output logic [1:0]        rf_dsel,
    output logic [1:0]        wb_sel,
    output logic              halted,
    output logic              err,
    output logic [2:0]        state
);
    localparam logic [2:0] S_RST    = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    if (MEM_WAIT_MAX < 1 || MEM_WAIT_MAX > 255) begin : g_bad_cfg
        $error("MEM_WAIT_MAX must be 1..255");
    end

    logic [2:0] state_d;
    logic       err_d;
    logic [4:0] op;
    logic       unused_instr;

    assign op           = instr[15:11];
    assign unused_instr = ^instr[10:0];

    logic op_halt, op_ill, op_nop, op_br;
    logic op_j, op_jr, op_jal, op_jalr;
    logic op_st, op_ld, op_stu, op_imm8;
    logic pc_only, mem_op, req_st, timeout;

    assign op_halt = (op == 5'b00000);
    assign op_ill  = (op == 5'b00010) || (op == 5'b00011);
    assign op_nop  = (op == 5'b00001);
    assign op_br   = (op[4:2] == 3'b011);
    assign op_j    = (op == 5'b00100);
    assign op_jr   = (op == 5'b00101);
    assign op_jal  = (op == 5'b00110);
    assign op_jalr = (op == 5'b00111);
    assign op_st   = (op == 5'b10000);
    assign op_ld   = (op == 5'b10001);
    assign op_stu  = (op == 5'b10011);
    assign op_imm8 = (op == 5'b11000) || (op == 5'b10010);

    assign pc_only = op_nop | op_br | op_j | op_jr;
    assign mem_op  = op_st | op_ld | op_stu;
    assign req_st  = (state == S_FETCH) || (state == S_MEM);

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_d;

    // Count only while parked in a request state; any transition clears it.
    assign timeout = req_st && !mem.mem_done &&
                     (wait_cnt == 8'(MEM_WAIT_MAX - 1));

    always_comb begin
        wait_cnt_d = '0;
        if (req_st && state_d == state)
            wait_cnt_d = wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state;
        err_d   = err;
        case (state)
            S_RST:    state_d = S_FETCH;
            S_FETCH: begin
                if (mem.mem_done) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end
            S_DECODE: begin
                if (op_halt) begin
                    state_d = S_HALT;
                end else if (op_ill) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    pc_only: state_d = S_FETCH;
                    mem_op:  state_d = S_MEM;
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem.mem_done) begin
                    state_d = op_st ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            err   <= err_d;
        end
    end

    always_comb begin
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        alu_latch    = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_wr   = 1'b0;
        mem.mem_isel = 1'b0;
        rf_we        = 1'b0;
        rf_dsel      = 2'b00;
        wb_sel       = 2'b00;
        halted       = 1'b0;
        case (state)
            S_FETCH: begin
                mem.mem_req  = 1'b1;
                mem.mem_isel = 1'b1;
                ir_we        = mem.mem_done;
            end
            S_EXEC: begin
                alu_latch = 1'b1;
                pc_we     = pc_only;
                unique case (1'b1)
                    op_br:   pc_sel = alu_zero ? 2'b01 : 2'b00;
                    op_j:    pc_sel = 2'b10;
                    op_jr:   pc_sel = 2'b11;
                    default: pc_sel = 2'b00;
                endcase
            end
            S_MEM: begin
                mem.mem_req = 1'b1;
                mem.mem_wr  = op_st | op_stu;
                pc_we       = op_st & mem.mem_done;
            end
            S_WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                // JALR jumps to the latched result, so linking into R7 is safe.
                unique case (1'b1)
                    op_ld: wb_sel = 2'b01;
                    op_stu, op_imm8: rf_dsel = 2'b01;
                    op_jal: begin
                        wb_sel  = 2'b10;
                        rf_dsel = 2'b10;
                        pc_sel  = 2'b10;
                    end
                    op_jalr: begin
                        wb_sel  = 2'b10;
                        rf_dsel = 2'b10;
                        pc_sel  = 2'b11;
                    end
                    default: ;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl.
// Expected per-cycle outputs come from an instruction phase-list model.
module tb_multicycle_ctrl;
    localparam int WAIT_LIM = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       alu_latch;
        logic       mem_req;
        logic       mem_wr;
        logic       mem_isel;
        logic       rf_we;
        logic [1:0] rf_dsel;
        logic [1:0] wb_sel;
        logic       halted;
        logic       err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        alu_zero;
    logic        mem_done;
    logic        ir_we, pc_we, alu_latch, rf_we, halted, err;
    logic [1:0]  pc_sel, rf_dsel, wb_sel;
    logic [2:0]  state;
    exp_t        obs;

    int vectors;
    int miscompares;

    multicycle_ctrl_if ifc ();

    assign ifc.mem_done = mem_done;

    multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_LIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .alu_zero  (alu_zero),
        .mem       (ifc.master),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .alu_latch (alu_latch),
        .rf_we     (rf_we),
        .rf_dsel   (rf_dsel),
        .wb_sel    (wb_sel),
        .halted    (halted),
        .err       (err),
        .state     (state)
    );

    assign obs = {state, ir_we, pc_we, pc_sel, alu_latch,
                  ifc.mem_req, ifc.mem_wr, ifc.mem_isel,
                  rf_we, rf_dsel, wb_sel, halted, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds the expected cycle list for one instruction, then plays it.
    // fw/mw < 0 means memory never answers; nhalt = HALT cycles to watch.
    task automatic run_instr(input string name, input logic [4:0] op,
                             input logic z, input int fw, input int mw,
                             input int nhalt);
        exp_t eq[$];
        bit   dq[$];
        exp_t e;
        bit   is_halt, is_ill, is_nop, is_br, is_j, is_jr, is_jal;
        bit   is_jalr, is_st, is_ld, is_stu, is_lbi;
        bit   halt_to, herr;
        is_halt = (op == 5'b00000);
        is_ill  = (op == 5'b00010) || (op == 5'b00011);
        is_nop  = (op == 5'b00001);
        is_br   = (op >= 5'b01100) && (op <= 5'b01111);
        is_j    = (op == 5'b00100);
        is_jr   = (op == 5'b00101);
        is_jal  = (op == 5'b00110);
        is_jalr = (op == 5'b00111);
        is_st   = (op == 5'b10000);
        is_ld   = (op == 5'b10001);
        is_stu  = (op == 5'b10011);
        is_lbi  = (op == 5'b11000) || (op == 5'b10010);
        halt_to = 0;
        herr    = 0;
        e = '0; e.st = 3'd1; e.mem_req = 1; e.mem_isel = 1;
        if (fw < 0) begin
            repeat (WAIT_LIM) begin eq.push_back(e); dq.push_back(0); end
            halt_to = 1; herr = 1;
        end else begin
            repeat (fw) begin eq.push_back(e); dq.push_back(0); end
            e.ir_we = 1;
            eq.push_back(e); dq.push_back(1);
            e = '0; e.st = 3'd2;
            eq.push_back(e); dq.push_back(bit'($urandom_range(0, 1)));
            if (is_halt || is_ill) begin
                halt_to = 1; herr = is_ill;
            end else begin
                e = '0; e.st = 3'd3; e.alu_latch = 1;
                if (is_nop) e.pc_we = 1;
                if (is_br) begin e.pc_we = 1; e.pc_sel = z ? 2'b01 : 2'b00; end
                if (is_j) begin e.pc_we = 1; e.pc_sel = 2'b10; end
                if (is_jr) begin e.pc_we = 1; e.pc_sel = 2'b11; end
                eq.push_back(e); dq.push_back(bit'($urandom_range(0, 1)));
                if (is_st || is_ld || is_stu) begin
                    e = '0; e.st = 3'd4; e.mem_req = 1; e.mem_wr = is_st || is_stu;
                    if (mw < 0) begin
                        repeat (WAIT_LIM) begin eq.push_back(e); dq.push_back(0); end
                        halt_to = 1; herr = 1;
                    end else begin
                        repeat (mw) begin eq.push_back(e); dq.push_back(0); end
                        if (is_st) e.pc_we = 1;
                        eq.push_back(e); dq.push_back(1);
                    end
                end
                if (!halt_to && !(is_nop || is_br || is_j || is_jr || is_st)) begin
                    e = '0; e.st = 3'd5; e.rf_we = 1; e.pc_we = 1;
                    if (is_ld) e.wb_sel = 2'b01;
                    if (is_stu || is_lbi) e.rf_dsel = 2'b01;
                    if (is_jal) begin e.wb_sel = 2'b10; e.rf_dsel = 2'b10; e.pc_sel = 2'b10; end
                    if (is_jalr) begin e.wb_sel = 2'b10; e.rf_dsel = 2'b10; e.pc_sel = 2'b11; end
                    eq.push_back(e); dq.push_back(bit'($urandom_range(0, 1)));
                end
            end
        end
        if (halt_to) begin
            e = '0; e.st = 3'd6; e.halted = 1; e.err = herr;
            repeat (nhalt) begin eq.push_back(e); dq.push_back(bit'($urandom_range(0, 1))); end
        end
        foreach (eq[k]) begin
            @(negedge clk);
            if (k == 0) begin
                instr    = {op, 11'($urandom)};
                alu_zero = z;
            end
            mem_done = dq[k];
            #1;
            vectors++;
            if (obs !== eq[k]) begin
                miscompares++;
                $display("FAIL %s op=%b cyc=%0d got=%h exp=%h",
                         name, op, k, obs, eq[k]);
            end
        end
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        mem_done = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_hold got=%h exp=%h", obs, exp_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_release got=%h exp=%h", obs, exp_t'(0));
        end
    endtask

    task automatic test_reset;
        do_reset();
    endtask

    task automatic test_add;
        run_instr("add", 5'b11011, 1'b0, 0, 0, 0);
        run_instr("add_again", 5'b11011, 1'b1, 0, 0, 0);
    endtask

    task automatic test_ld_wait;
        run_instr("ld_wait", 5'b10001, 1'b0, 0, 3, 0);
        run_instr("stu_wait", 5'b10011, 1'b0, 2, 1, 0);
        run_instr("st_zero", 5'b10000, 1'b0, 0, 0, 0);
    endtask

    task automatic test_branch;
        run_instr("beqz_taken", 5'b01100, 1'b1, 0, 0, 0);
        run_instr("beqz_not", 5'b01100, 1'b0, 0, 0, 0);
        run_instr("j", 5'b00100, 1'b0, 1, 0, 0);
        run_instr("jr", 5'b00101, 1'b1, 0, 0, 0);
    endtask

    task automatic test_jalr;
        run_instr("jalr", 5'b00111, 1'b0, 0, 0, 0);
        run_instr("jal", 5'b00110, 1'b1, 1, 0, 0);
        run_instr("lbi", 5'b11000, 1'b0, 0, 0, 0);
        run_instr("slbi", 5'b10010, 1'b0, 0, 0, 0);
    endtask

    task automatic test_random;
        logic [4:0] op;
        for (int n = 0; n < 150; n++) begin
            do op = 5'($urandom_range(1, 31));
            while (op == 5'b00010 || op == 5'b00011);
            run_instr("random", op, 1'($urandom),
                      $urandom_range(0, WAIT_LIM - 1),
                      $urandom_range(0, WAIT_LIM - 1), 0);
        end
    endtask

    task automatic test_illegal;
        run_instr("illegal_00010", 5'b00010, 1'b0, 1, 0, 21);
        do_reset();
        run_instr("illegal_00011", 5'b00011, 1'b0, 0, 0, 5);
        do_reset();
    endtask

    task automatic test_halt_op;
        run_instr("halt", 5'b00000, 1'b0, 0, 0, 10);
        do_reset();
    endtask

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        run_instr("fetch_timeout", 5'b11011, 1'b0, -1, 0, 5);
        do_reset();
        run_instr("mem_timeout", 5'b10001, 1'b0, 0, -1, 5);
        do_reset();
    endtask
`else
    task automatic test_wait;
        exp_t e;
        e = '0; e.st = 3'd1; e.mem_req = 1; e.mem_isel = 1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            mem_done = 1'b0;
            #1;
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL fetch_wait cyc=%0d got=%h exp=%h", k, obs, e);
            end
        end
        do_reset();
    endtask
`endif

    task automatic test_async_reset;
        run_instr("pre_reset_add", 5'b11011, 1'b0, 0, 0, 0);
        @(negedge clk);
        mem_done = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=%h", obs, exp_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL async_release got=%h exp=%h", obs, exp_t'(0));
        end
        run_instr("post_reset_ld", 5'b10001, 1'b1, 0, 0, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        instr       = '0;
        alu_zero    = 1'b0;
        mem_done    = 1'b0;
        test_reset();
        test_add();
        test_ld_wait();
        test_branch();
        test_jalr();
        test_random();
        test_illegal();
        test_halt_op();
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_wait();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
